// File: rtl/hex_scan_ctrl_if.sv
// Load handshake and display-drive bundle for hex_scan_ctrl.
// master = score logic / display side, slave = the scan controller.
interface hex_scan_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  i_load_vld;
  logic [4*DIGITS-1:0]   i_load_dat;
  logic                  o_load_rdy;
  logic [3:0]            o_dec_dat;
  logic [DIGITS-1:0]     o_dig_n;
  logic                  o_frame;

  modport master (
    output i_load_vld,
    output i_load_dat,
    input  o_load_rdy,
    input  o_dec_dat,
    input  o_dig_n,
    input  o_frame
  );

  modport slave (
    input  i_load_vld,
    input  i_load_dat,
    output o_load_rdy,
    output o_dec_dat,
    output o_dig_n,
    output o_frame
  );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a double-buffered digit image.
// Define HEX_SCAN_LZB_EN to enable leading-zero blanking.
module hex_scan_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  hex_scan_ctrl_if.slave bus
);

  typedef enum logic {StBlank, StShow} state_e;

  localparam int unsigned ImgW   = 4 * DIGITS;
  localparam int unsigned CntMax = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] TickLast  = CntW'(TICK_DIV - 1);
  localparam logic [2:0]      IdxLast   = 3'(DIGITS - 1);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ImgW-1:0]   active_q, active_d;
  logic [ImgW-1:0]   shadow_q, shadow_d;
  logic              pend_q, pend_d;
  logic [3:0]        dec_dat_q, dec_dat_d;
  logic [DIGITS-1:0] dig_n_q, dig_n_d;
  logic              frame_q, frame_d;

  logic              commit;
  logic              show_ok;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    commit   = 1'b0;

    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShow: begin
        if (cnt_q == TickLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          if (idx_q == IdxLast) begin
            idx_d  = '0;
            commit = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StBlank;
    endcase

    // Transfer needs !pend and commit needs pend, so these never collide.
    if (bus.i_load_vld && !pend_q) begin
      shadow_d = bus.i_load_dat;
      pend_d   = 1'b1;
    end
    if (commit && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
  end

  // Outputs are registered from next-state so they line up with the FSM cycle.
  always_comb begin
    dec_dat_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_d == 3'(i)) begin
        dec_dat_d = active_d[4*i +: 4];
      end
    end

`ifdef HEX_SCAN_LZB_EN
    show_ok = (idx_d == 3'd0);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((3'(i) >= idx_d) && (active_d[4*i +: 4] != 4'd0)) begin
        show_ok = 1'b1;
      end
    end
`else
    show_ok = 1'b1;
`endif

    dig_n_d = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((state_d == StShow) && (idx_d == 3'(i)) && show_ok) begin
        dig_n_d[i] = 1'b0;
      end
    end

    frame_d = commit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StBlank;
      idx_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      dec_dat_q <= '0;
      dig_n_q   <= '1;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      dec_dat_q <= dec_dat_d;
      dig_n_q   <= dig_n_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.o_load_rdy = ~pend_q;
  assign bus.o_dec_dat  = dec_dat_q;
  assign bus.o_dig_n    = dig_n_q;
  assign bus.o_frame    = frame_q;

endmodule
